// File: rtl/score_keeper.sv
// score_keeper: rhythm-game scorer with countdown, streak multiplier and saturating packed-BCD score.
module score_keeper #(
    parameter int READY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       song_done,
    output logic [7:0] score,
    output logic [2:0] mode,
    output logic [2:0] mult
);
    localparam int CW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(READY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        READY  = 3'b001,
        PLAY   = 3'b010,
        FINISH = 3'b101
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    streak_q, streak_d;
    logic [4:0]    ones_sum;
    logic [3:0]    tens_sum;
    logic          carry;

    assign score = score_q;
    assign mode  = state_q;
    assign mult  = {1'b0, streak_q[3:2]} + 3'd1;

    // mult never exceeds 4, so a single carry into tens is enough
    assign ones_sum = {1'b0, score_q[3:0]} + {2'b00, mult};
    assign carry    = ones_sum > 5'd9;
    assign tens_sum = score_q[7:4] + {3'b000, carry};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        streak_d = streak_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d  = READY;
                    cnt_d    = '0;
                    score_d  = 8'h00;
                    streak_d = 4'd0;
                end
            end
            READY: begin
                state_d = (cnt_q == LAST) ? PLAY : READY;
                cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
            PLAY: begin
                if (miss) begin
                    streak_d = 4'd0;
                end else if (hit) begin
                    streak_d = (streak_q == 4'd15) ? streak_q : streak_q + 4'd1;
                    score_d  = (tens_sum > 4'd9) ? 8'h99
                             : {tens_sum, carry ? ones_sum[3:0] - 4'd10 : ones_sum[3:0]};
                end
                if (song_done) state_d = FINISH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            score_q  <= 8'h00;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end
endmodule
